// File: rtl/staged_barrel_shifter.sv
// staged_barrel_shifter: multi-cycle barrel shifter with a valid/ready handshake
// on both sides. A shift command takes one cycle per stage (largest stage first)
// so latency does not depend on the shift amount. The result register o is also
// the operand of every shift command.
//
// Build option: define BARREL_ROTATE_EN to enable ROL/ROR (opcodes 4 and 5).
// Without it those opcodes are treated as illegal and no rotate logic exists.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a command, in_ready=1, o holds last result
// ST_SHIFT | applying one 2^k stage per cycle, k = SW-1 down to 0
// ST_DONE  | result valid on o, waiting for out_ready
module staged_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         i,
    input  logic [$clog2(WIDTH)-1:0] s,
    input  logic [2:0]               c,
    output logic [WIDTH-1:0]         o,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     err
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_SHR  = 3'd2;
    localparam logic [2:0] OP_SAR  = 3'd3;
`ifdef BARREL_ROTATE_EN
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [SW:0] W_AMT  = (SW+1)'(WIDTH);
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             err_q, err_d;
    logic [SW-1:0]    s_q, s_d;       // shifted left each stage; MSB is the current stage bit
    logic [2:0]       c_q, c_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [SW:0]      amt;
    logic [WIDTH-1:0] stage_res;
    logic             legal;

    // Opcode legality of the command presented on c.
    always_comb begin
        legal = 1'b0;
        case (c)
            OP_LOAD, OP_SHL, OP_SHR, OP_SAR: legal = 1'b1;
`ifdef BARREL_ROTATE_EN
            OP_ROL, OP_ROR:                  legal = 1'b1;
`endif
            default:                         legal = 1'b0;
        endcase
    end

    // One stage of the shift: move o by 2^stage according to the captured opcode.
    // SAR keeps o[WIDTH-1] at every stage, so the fill is the original sign bit.
    always_comb begin
        amt       = (SW+1)'(1) << stage_q;
        stage_res = o_q;
        case (c_q)
            OP_SHL: stage_res = o_q << amt;
            OP_SHR: stage_res = o_q >> amt;
            OP_SAR: stage_res = $signed(o_q) >>> amt;
`ifdef BARREL_ROTATE_EN
            OP_ROL: stage_res = (o_q << amt) | (o_q >> (W_AMT - amt));
            OP_ROR: stage_res = (o_q >> amt) | (o_q << (W_AMT - amt));
`endif
            default: stage_res = o_q;
        endcase
    end

    // Next-state and datapath updates; everything holds unless a transition says otherwise.
    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        err_d   = err_q;
        s_d     = s_q;
        c_d     = c_q;
        stage_d = stage_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    c_d     = c;
                    s_d     = s;
                    stage_d = SW'(SW-1);
                    if (!legal) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (c == OP_LOAD) begin
                        o_d     = i;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (s_q[SW-1]) begin
                    o_d = stage_res;
                end
                s_d = s_q << 1;
                if (stage_q == '0) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    stage_d = stage_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset clears the result and aborts any command in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q     <= '0;
            err_q   <= 1'b0;
            s_q     <= '0;
            c_q     <= '0;
            stage_q <= '0;
        end else begin
            o_q     <= o_d;
            err_q   <= err_d;
            s_q     <= s_d;
            c_q     <= c_d;
            stage_q <= stage_d;
        end
    end

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign o         = o_q;
    assign err       = err_q;

endmodule

// File: doc/staged_barrel_shifter.md
STAGED_BARREL_SHIFTER -- requirements
Module: staged_barrel_shifter

Interface
REQ-001 Parameter: WIDTH, 8, data width in bits; SHALL be a power of two, at least 4.
REQ-002 Derived localparam: SW, $clog2(WIDTH), shift-amount width and number of shift stages.
REQ-003 Port: clk  input  1  rising-edge clock, the only clock in the block.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: in_valid  input  1  a command is present on i/s/c.
REQ-006 Port: in_ready  output  1  the block can accept a command.
REQ-007 Port: i  input  WIDTH  load data.
REQ-008 Port: s  input  SW  shift amount.
REQ-009 Port: c  input  3  opcode: 0 LOAD, 1 SHL, 2 SHR (logical), 3 SAR (arithmetic), 4 ROL, 5 ROR, 6 and 7 illegal.
REQ-010 Port: o  output  WIDTH  result register; it is also the operand of every shift command.
REQ-011 Port: out_valid  output  1  o holds a completed result.
REQ-012 Port: out_ready  input  1  the consumer accepts the result.
REQ-013 Port: err  output  1  the last completed command was illegal.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 A command is accepted on a clock edge where in_valid=1 and in_ready=1; i, s and c SHALL be captured at that edge.
REQ-016 LOAD: o<=i and the FSM goes IDLE->DONE; the result is visible one cycle after acceptance.
REQ-017 Shift opcodes: the FSM goes IDLE->SHIFT and stays exactly SW cycles; the cycle for stage k (k=SW-1 down to 0) shifts o by 2^k when captured s[k]=1, otherwise o holds; the FSM then enters DONE. Latency SHALL be fixed at SW+1 cycles from acceptance to out_valid, independent of s.
REQ-018 s=0 on a shift opcode SHALL still take SW SHIFT cycles and leave o unchanged.
REQ-019 Fill rules: SHL fills with 0 from the LSB; SHR fills with 0 from the MSB; SAR fills with the original o[WIDTH-1]; ROL and ROR wrap the bits around. No bits SHALL come from i.
REQ-020 Illegal opcode: the FSM goes IDLE->DONE in one cycle, o is unchanged, and err=1.
REQ-021 Any legal command SHALL clear err when it reaches DONE.
REQ-022 In DONE: out_valid=1 and o is stable. The FSM leaves DONE->IDLE on the edge where out_ready=1, and out_valid falls in the same edge. No command is accepted in DONE, so a new command is accepted at the earliest one cycle after the handshake.
REQ-023 In IDLE and SHIFT, out_valid SHALL be 0. In IDLE, o SHALL hold its last value.
REQ-024 Changes on i, s or c after acceptance SHALL have no effect on the command in flight.

Reset
REQ-025 With rst_n=0 at a clock edge: state<=IDLE, o<=0, out_valid<=0, err<=0.
REQ-026 in_ready SHALL be 0 while rst_n=0, and 1 in the first cycle after rst_n rises.
REQ-027 Reset during SHIFT or DONE SHALL abort the command, and no out_valid SHALL be produced for it.

Configuration
REQ-028 Macro BARREL_ROTATE_EN defined: opcodes 4 (ROL) and 5 (ROR) SHALL execute as specified above.
REQ-029 Macro BARREL_ROTATE_EN undefined: opcodes 4 and 5 SHALL be illegal per REQ-020, and no rotate logic SHALL be synthesised.

Verification (WIDTH=8, SW=3)
REQ-030 LOAD 0x81, then SHL with s=3 -> o=0x08, out_valid rises 4 cycles after acceptance, err=0.
REQ-031 LOAD 0x80, then SAR with s=7 -> o=0xFF; LOAD 0x80, then SHR with s=7 -> o=0x01.
REQ-032 BARREL_ROTATE_EN defined: LOAD 0x81, then ROR with s=1 -> o=0xC0. Undefined: the same ROR -> o=0x81, err=1, out_valid after 1 cycle.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE -> o and out_valid stable and in_ready=0 throughout; the handshake completes on the edge where out_ready=1, and in_ready=1 the next cycle.
REQ-034 Reset in the 2nd SHIFT cycle of SHL with s=5 on o=0xFF -> next cycle o=0x00, out_valid=0, in_ready=1 after release, and no result is emitted.
